// File: rtl/pe_packet_tx.sv
// PE packet network transmit source: queues burst requests in a FIFO and expands each
// request into `count` packets to consecutive node addresses carrying the same payload.
module pe_packet_tx #(
  parameter int unsigned NODE_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NODE_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic [CNT_W-1:0]         req_count,
  output logic                     packet_out_valid,
  input  logic                     packet_out_ready,
  output logic [NODE_W+DATA_W-1:0] packet_out,
  output logic                     busy,
  output logic                     tx_done,
  output logic [15:0]              pkt_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = NODE_W + DATA_W;

  typedef struct packed {
    logic [NODE_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Request FIFO: pointers carry one extra wrap bit to tell full from empty.
  req_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  req_t          head;
  req_t          wr_entry;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_entry       = '0;
    wr_entry.addr  = req_addr;
    wr_entry.data  = req_data;
    wr_entry.count = req_count;
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Burst expansion FSM
  state_t            state;
  state_t            state_nxt;
  logic [NODE_W-1:0] cur_addr;
  logic [NODE_W-1:0] cur_addr_nxt;
  logic [NODE_W-1:0] addr_inc;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] cur_data_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  remaining_nxt;
  logic              valid_nxt;
  logic [PW-1:0]     packet_nxt;
  logic              done_nxt;
  logic [15:0]       pkt_count_nxt;

  assign addr_inc = cur_addr + NODE_W'(1);
  assign busy     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    cur_addr_nxt  = cur_addr;
    cur_data_nxt  = cur_data;
    remaining_nxt = remaining;
    valid_nxt     = packet_out_valid;
    packet_nxt    = packet_out;
    done_nxt      = 1'b0;
    pkt_count_nxt = pkt_count;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          cur_addr_nxt  = head.addr;
          cur_data_nxt  = head.data;
          remaining_nxt = head.count;
          if (head.count == CNT_W'(0)) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt  = SEND;
            valid_nxt  = 1'b1;
            packet_nxt = {head.addr, head.data};
          end
        end
      end
      SEND: begin
        // Output is held untouched while the network stalls.
        if (packet_out_ready) begin
          pkt_count_nxt = pkt_count + 16'd1;
          if (remaining == CNT_W'(1)) begin
            state_nxt     = IDLE;
            valid_nxt     = 1'b0;
            done_nxt      = 1'b1;
            remaining_nxt = '0;
          end else begin
            remaining_nxt = remaining - CNT_W'(1);
            cur_addr_nxt  = addr_inc;
            packet_nxt    = {addr_inc, cur_data};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr         <= '0;
      cur_data         <= '0;
      remaining        <= '0;
      packet_out_valid <= 1'b0;
      packet_out       <= '0;
      tx_done          <= 1'b0;
      pkt_count        <= '0;
    end else begin
      cur_addr         <= cur_addr_nxt;
      cur_data         <= cur_data_nxt;
      remaining        <= remaining_nxt;
      packet_out_valid <= valid_nxt;
      packet_out       <= packet_nxt;
      tx_done          <= done_nxt;
      pkt_count        <= pkt_count_nxt;
    end
  end

endmodule

// File: tb/tb_pe_packet_tx.sv
// Directed self-checking bench for pe_packet_tx: burst expansion, address wrap, stall,
// FIFO full, zero-count requests and mid-burst reset.
module tb_pe_packet_tx;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic [7:0]  req_count;
  logic        packet_out_valid;
  logic        packet_out_ready;
  logic [41:0] packet_out;
  logic        busy;
  logic        tx_done;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  pe_packet_tx #(.NODE_W(10), .DATA_W(32), .CNT_W(8), .DEPTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_count        (req_count),
    .packet_out_valid (packet_out_valid),
    .packet_out_ready (packet_out_ready),
    .packet_out       (packet_out),
    .busy             (busy),
    .tx_done          (tx_done),
    .pkt_count        (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request for one edge, starting at a negedge.
  task automatic push(input logic [9:0] a, input logic [31:0] d, input logic [7:0] c);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_count = c;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait at most max_wait cycles for a packet, check it, step past its handshake.
  task automatic expect_pkt(input string tag, input logic [9:0] a, input logic [31:0] d,
                            input int max_wait);
    int w = 0;
    while (!packet_out_valid && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " valid"}, 64'(packet_out_valid), 64'd1);
    chk({tag, " pkt"}, 64'(packet_out), 64'({a, d}));
    @(negedge clk);
  endtask

  logic [41:0] seen_pkt [8];
  int          n_seen;
  int          n_done;

  initial begin
    rst_n            = 1'b0;
    req_valid        = 1'b0;
    req_addr         = '0;
    req_data         = '0;
    req_count        = '0;
    packet_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst valid", 64'(packet_out_valid), 64'd0);
    chk("rst pkt", 64'(packet_out), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(tx_done), 64'd0);
    chk("rst count", 64'(pkt_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single packet
    push(10'd2, 32'hDEADBEEF, 8'd1);
    chk("t1 busy queued", 64'(busy), 64'd1);
    chk("t1 valid before pop", 64'(packet_out_valid), 64'd0);
    expect_pkt("t1 p0", 10'd2, 32'hDEADBEEF, 1);
    chk("t1 valid after", 64'(packet_out_valid), 64'd0);
    chk("t1 done", 64'(tx_done), 64'd1);
    chk("t1 count", 64'(pkt_count), 64'd1);
    chk("t1 busy idle", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t1 done pulse", 64'(tx_done), 64'd0);

    // 2: address wrap within a burst, one packet per cycle
    push(10'h3FE, 32'd5, 8'd4);
    expect_pkt("t2 p0", 10'h3FE, 32'd5, 1);
    expect_pkt("t2 p1", 10'h3FF, 32'd5, 0);
    expect_pkt("t2 p2", 10'h000, 32'd5, 0);
    expect_pkt("t2 p3", 10'h001, 32'd5, 0);
    chk("t2 valid after", 64'(packet_out_valid), 64'd0);
    chk("t2 done", 64'(tx_done), 64'd1);
    chk("t2 count", 64'(pkt_count), 64'd5);

    // 3: stall mid-burst freezes the output
    @(negedge clk);
    push(10'h100, 32'hA5A5A5A5, 8'd3);
    expect_pkt("t3 p0", 10'h100, 32'hA5A5A5A5, 1);
    packet_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3 stall valid %0d", i), 64'(packet_out_valid), 64'd1);
      chk($sformatf("t3 stall pkt %0d", i), 64'(packet_out), 64'({10'h101, 32'hA5A5A5A5}));
      chk($sformatf("t3 stall count %0d", i), 64'(pkt_count), 64'd6);
    end
    packet_out_ready = 1'b1;
    expect_pkt("t3 p1", 10'h101, 32'hA5A5A5A5, 0);
    expect_pkt("t3 p2", 10'h102, 32'hA5A5A5A5, 0);
    chk("t3 valid after", 64'(packet_out_valid), 64'd0);
    chk("t3 done", 64'(tx_done), 64'd1);
    chk("t3 count", 64'(pkt_count), 64'd8);

    // 4: fill while stalled; head is in flight, 8 more fit, the 10th is refused
    @(negedge clk);
    packet_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4 ready %0d", i), 64'(req_ready), (i < 9) ? 64'd1 : 64'd0);
      req_valid = 1'b1;
      req_addr  = 10'(i * 16);
      req_data  = 32'(i);
      req_count = 8'd1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("t4 full ready", 64'(req_ready), 64'd0);
    chk("t4 busy", 64'(busy), 64'd1);
    packet_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      expect_pkt($sformatf("t4 p%0d", i), 10'(i * 16), 32'(i), 0);
      chk($sformatf("t4 gap valid %0d", i), 64'(packet_out_valid), 64'd0);
      chk($sformatf("t4 gap done %0d", i), 64'(tx_done), 64'd1);
      @(negedge clk);
    end
    chk("t4 drained valid", 64'(packet_out_valid), 64'd0);
    chk("t4 drained busy", 64'(busy), 64'd0);
    chk("t4 count", 64'(pkt_count), 64'd17);

    // 5: zero-count request between two 2-packet bursts
    packet_out_ready = 1'b0;
    push(10'h020, 32'h11, 8'd2);
    push(10'h030, 32'h22, 8'd0);
    push(10'h040, 32'h33, 8'd2);
    packet_out_ready = 1'b1;
    n_seen = 0;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (packet_out_valid) begin
        if (n_seen < 8) seen_pkt[n_seen] = packet_out;
        n_seen++;
      end
      if (tx_done) n_done++;
      @(negedge clk);
    end
    chk("t5 packets", 64'(n_seen), 64'd4);
    chk("t5 dones", 64'(n_done), 64'd3);
    chk("t5 p0", 64'(seen_pkt[0]), 64'({10'h020, 32'h11}));
    chk("t5 p1", 64'(seen_pkt[1]), 64'({10'h021, 32'h11}));
    chk("t5 p2", 64'(seen_pkt[2]), 64'({10'h040, 32'h33}));
    chk("t5 p3", 64'(seen_pkt[3]), 64'({10'h041, 32'h33}));
    chk("t5 count", 64'(pkt_count), 64'd21);

    // 6: asynchronous reset while stalled mid-burst with a request queued
    packet_out_ready = 1'b0;
    push(10'h050, 32'h77, 8'd3);
    push(10'h060, 32'h88, 8'd2);
    chk("t6 valid pre", 64'(packet_out_valid), 64'd1);
    chk("t6 busy pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst valid", 64'(packet_out_valid), 64'd0);
    chk("t6 rst pkt", 64'(packet_out), 64'd0);
    chk("t6 rst busy", 64'(busy), 64'd0);
    chk("t6 rst count", 64'(pkt_count), 64'd0);
    chk("t6 rst ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n            = 1'b1;
    packet_out_ready = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (packet_out_valid) n_seen++;
    end
    chk("t6 residual", 64'(n_seen), 64'd0);
    chk("t6 count", 64'(pkt_count), 64'd0);
    chk("t6 busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
